dac_volt_gen: RTL



---
 rtl/dac_volt_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dac_volt_gen.sv
// Voltage-to-DAC code generator: converts a signed millivolt request into an
// 8-bit offset-binary code and drives it to a parallel DAC with a divided clock.
module dac_volt_gen #(
   parameter logic [7:0]  M        = 8'd127,
   parameter logic [12:0] VOLT_MAX = 13'd5000,
   parameter int          CLK_DIV  = 25
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        volt_valid,
   input  logic        volt_sign,
   input  logic [12:0] volt_mag,
   output logic        volt_ready,
   output logic        conv_done,
   output logic        da_clk,
   output logic [7:0]  da_data
);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [20:0]   POS_GAIN  = 21'(8'd255 - M);
   localparam logic [20:0]   ZERO_OFS  = 21'(VOLT_MAX) * 21'(M);
   localparam logic [13:0]   DIVISOR   = 14'(VOLT_MAX);
   localparam logic [4:0]    LAST_ITER = 5'd20;

   state_t        state;
   state_t        state_nxt;
   logic          sign_q;
   logic [12:0]   mag_q;
   logic [20:0]   num;
   logic [12:0]   rem;
   logic [7:0]    quo;
   logic [4:0]    iter;
   logic [7:0]    code_hold;
   logic [CW-1:0] div_cnt;
   logic [13:0]   rem_sh;
   logic          rem_ge;

   assign volt_ready = (state == IDLE);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (volt_valid) state_nxt = LOAD;
         LOAD:    state_nxt = DIV;
         DIV:     if (iter == LAST_ITER) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Restoring divide step: bring down the next numerator bit, subtract if it fits.
   assign rem_sh = {rem, num[20]};
   assign rem_ge = (rem_sh >= DIVISOR);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sign_q    <= 1'b0;
         mag_q     <= '0;
         num       <= '0;
         rem       <= '0;
         quo       <= '0;
         iter      <= '0;
         code_hold <= M;
         conv_done <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            IDLE: begin
               if (volt_valid) begin
                  sign_q <= volt_sign;
                  mag_q  <= (volt_mag > VOLT_MAX) ? VOLT_MAX : volt_mag;
               end
            end
            LOAD: begin
               num  <= sign_q ? 21'(VOLT_MAX - mag_q) * 21'(M)
                              : 21'(mag_q) * POS_GAIN + ZERO_OFS;
               rem  <= '0;
               quo  <= '0;
               iter <= '0;
            end
            DIV: begin
               rem  <= rem_ge ? 13'(rem_sh - DIVISOR) : rem_sh[12:0];
               num  <= {num[19:0], 1'b0};
               quo  <= {quo[6:0], rem_ge};
               iter <= iter + 5'd1;
            end
            OUT: begin
               code_hold <= quo;
               conv_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Free-running DAC clock; the code is updated on its falling edge so it is
   // stable for a full half-period before the DAC samples on the rising edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt <= '0;
         da_clk  <= 1'b0;
         da_data <= M;
      end else if (div_cnt == CNT_LAST) begin
         div_cnt <= '0;
         da_clk  <= ~da_clk;
         if (da_clk) da_data <= code_hold;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule
